cdb_arbiter_multi: RTL

- Parametrised successor to the single-lane CDB scheduler.
- Arbitrates NUM_SRC functional-unit result packets onto NUM_CDB parallel Common Data Bus lanes.
- Supports fixed-priority or round-robin selection, and registers the broadcast lanes.
- Sits between functional-unit output stages (valid/yumi handshake) and the ROB/reservation-station wakeup logic.

---
 rtl/cdb_arbiter_multi.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter_multi.sv
// rtl/cdb_arbiter_multi.sv - multi-lane Common Data Bus arbiter with registered broadcast lanes
//
// Purpose: grants up to NUM_CDB of NUM_SRC functional-unit result packets per
// cycle. Grants are made by fixed priority (PRIO_MODE=0, index 0 highest) or by
// round-robin (PRIO_MODE=1). Grant k goes to lane k. The lanes are registered,
// so a packet granted in cycle t is broadcast in cycle t+1.
//
// Optional feature: define CDB_AGE_PROMOTE_EN to enable per-source starvation
// counters. A source that has waited STARVE_LIMIT cycles becomes urgent and is
// granted ahead of non-urgent sources.
//
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   flush        - mispredict flush: no grants this cycle, lanes idle next cycle
//   src_valid    - per-source packet valid
//   src_rob      - per-source dest ROB entry, slice [i*ROB_IDX_W +: ROB_IDX_W]
//   src_result   - per-source result, slice [i*DATA_W +: DATA_W]
//   src_branch   - per-source branch_result bit
//   src_yumi     - per-source consume strobe, combinational
//   cdb_valid    - per-lane broadcast valid, registered
//   cdb_rob      - per-lane dest ROB entry
//   cdb_result   - per-lane result
//   cdb_branch   - per-lane branch_result bit
module cdb_arbiter_multi #(
  parameter int NUM_SRC      = 6,
  parameter int NUM_CDB      = 2,
  parameter int ROB_IDX_W    = 5,
  parameter int DATA_W       = 32,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*ROB_IDX_W-1:0]  src_rob,
  input  logic [NUM_SRC*DATA_W-1:0]     src_result,
  input  logic [NUM_SRC-1:0]            src_branch,
  output logic [NUM_SRC-1:0]            src_yumi,
  output logic [NUM_CDB-1:0]            cdb_valid,
  output logic [NUM_CDB*ROB_IDX_W-1:0]  cdb_rob,
  output logic [NUM_CDB*DATA_W-1:0]     cdb_result,
  output logic [NUM_CDB-1:0]            cdb_branch
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W:0]   NSRC_L  = NUM_SRC[PTR_W:0];
  localparam logic [PTR_W-1:0] NSRC_M1 = PTR_W'(NUM_SRC - 1);

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           next_ptr;
  logic                       any_grant;
  logic [NUM_SRC-1:0]         grant;
  logic [NUM_SRC-1:0]         urgent;
  logic [NUM_CDB-1:0]         lane_vld;
  logic [PTR_W-1:0]           lane_sel [NUM_CDB];
  logic [NUM_CDB*ROB_IDX_W-1:0] lane_rob;
  logic [NUM_CDB*DATA_W-1:0]    lane_res;
  logic [NUM_CDB-1:0]           lane_br;

`ifdef CDB_AGE_PROMOTE_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age [NUM_SRC];

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      urgent[s] = (age[s] == AGE_MAX);
    end
  end

  // Wait counters only run while a packet is actually stalled.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (reset || flush || !src_valid[s] || src_yumi[s]) begin
        age[s] <= '0;
      end else if (age[s] != AGE_MAX) begin
        age[s] <= age[s] + AGE_W'(1);
      end
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign urgent = '0;
`endif

  // Two passes over the scan order: urgent sources first, then the rest.
  // Without age promotion the first pass never takes anything.
  always_comb begin : arbitrate
    int             cnt;
    int             last_pos;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] start;
    logic [PTR_W-1:0] last_idx;
    logic             take;
    grant     = '0;
    lane_vld  = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      lane_sel[k] = '0;
    end
    any_grant = 1'b0;
    cnt       = 0;
    last_pos  = -1;
    sum       = '0;
    idx       = '0;
    last_idx  = '0;
    take      = 1'b0;
    start     = (PRIO_MODE == 1) ? rr_ptr : '0;
    if (!reset && !flush) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int p = 0; p < NUM_SRC; p++) begin
          sum = {1'b0, start} + p[PTR_W:0];
          if (sum >= NSRC_L) begin
            sum = sum - NSRC_L;
          end
          idx  = sum[PTR_W-1:0];
          take = src_valid[idx] && !grant[idx] && (cnt < NUM_CDB) &&
                 (urgent[idx] == (pass == 0));
          if (take) begin
            for (int k = 0; k < NUM_CDB; k++) begin
              if (k == cnt) begin
                lane_sel[k] = idx;
                lane_vld[k] = 1'b1;
              end
            end
            grant[idx] = 1'b1;
            cnt        = cnt + 1;
            any_grant  = 1'b1;
            // Pointer follows the furthest grant in scan order, urgent or not.
            if (p > last_pos) begin
              last_pos = p;
              last_idx = idx;
            end
          end
        end
      end
    end
    next_ptr = (last_idx == NSRC_M1) ? '0 : last_idx + PTR_W'(1);
  end

  assign src_yumi = grant;

  // Idle lanes carry all-zero fields.
  always_comb begin : lane_mux
    lane_rob = '0;
    lane_res = '0;
    lane_br  = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (lane_vld[k] && (lane_sel[k] == s[PTR_W-1:0])) begin
          lane_rob[k*ROB_IDX_W +: ROB_IDX_W] = src_rob[s*ROB_IDX_W +: ROB_IDX_W];
          lane_res[k*DATA_W +: DATA_W]       = src_result[s*DATA_W +: DATA_W];
          lane_br[k]                         = src_branch[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid  <= '0;
      cdb_rob    <= '0;
      cdb_result <= '0;
      cdb_branch <= '0;
      rr_ptr     <= '0;
    end else begin
      cdb_valid  <= lane_vld;
      cdb_rob    <= lane_rob;
      cdb_result <= lane_res;
      cdb_branch <= lane_br;
      if (any_grant) begin
        rr_ptr <= next_ptr;
      end
    end
  end

endmodule
